// File: rtl/f2_operand_fetch.sv
// rtl/f2_operand_fetch.sv - operand sequencer feeding the P-lane f2 array (d = min(a,b) + c)
module f2_operand_fetch #(
  parameter int Q  = 10,
  parameter int P  = 64,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  input  logic [AW-1:0]   addr_c,
  input  logic            c_zero,
  output logic            busy,
  output logic            mem_ren,
  output logic [AW-1:0]   mem_raddr,
  input  logic [P*Q-1:0]  mem_rdata,
  output logic [P*Q-1:0]  a,
  output logic [P*Q-1:0]  b,
  output logic [P*Q-1:0]  c,
  output logic            enable
);

  // RA: address A is on the bus; RB/RC/CAP: the previous read's data is on mem_rdata.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RB,
    S_RC,
    S_CAP,
    S_OUT
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr_b_q;
  logic [AW-1:0]   addr_c_q;
  logic            c_zero_q;

  // A request is in flight whenever the sequencer has left IDLE (includes the enable cycle).
  assign busy = (state != S_IDLE);

  // Request sequencer: issues reads back to back, captures each vector one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      enable    <= 1'b0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      c_zero_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          enable <= 1'b0;
          if (start) begin
            // addr_a goes straight to the bus; only the later addresses need holding.
            addr_b_q  <= addr_b;
            addr_c_q  <= addr_c;
            c_zero_q  <= c_zero;
            mem_ren   <= 1'b1;
            mem_raddr <= addr_a;
            state     <= S_RA;
          end
        end
        S_RA: begin
          mem_raddr <= addr_b_q;
          state     <= S_RB;
        end
        S_RB: begin
          a <= mem_rdata;
          if (c_zero_q) begin
            // Last read (B) was issued in RA/RB; stop reading, mem_raddr holds.
            mem_ren <= 1'b0;
            state   <= S_CAP;
          end else begin
            mem_raddr <= addr_c_q;
            state     <= S_RC;
          end
        end
        S_RC: begin
          b       <= mem_rdata;
          mem_ren <= 1'b0;
          state   <= S_CAP;
        end
        S_CAP: begin
          if (c_zero_q) begin
            b <= mem_rdata;
            c <= '0;
          end else begin
            c <= mem_rdata;
          end
          enable <= 1'b1;
          state  <= S_OUT;
        end
        S_OUT: begin
          enable <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          mem_ren <= 1'b0;
          enable  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/f2_operand_fetch.md
# f2_operand_fetch

Operand sequencer directly upstream of the P-lane `f2` processing array (d = min(a, b) + c) in the SCAN decoder PE. On a start request it reads up to three P×Q-bit LLR/bit vectors from a single-port, 1-cycle-latency memory. It holds the vectors stable on the `a`, `b` and `c` buses and pulses `enable` for one cycle when all three are valid. The array's `d` output is sampled by the downstream writeback during that pulse.

## Interface
- Q, default 10: bits per lane (two's complement).
- P, default 64: lanes per vector.
- AW, default 8: memory address width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when `busy`=0.
- addr_a  in  AW  address of operand a; sampled with start.
- addr_b  in  AW  address of operand b; sampled with start.
- addr_c  in  AW  address of operand c; sampled with start.
- c_zero  in  1  1 = skip c read, drive c = 0; sampled with start.
- busy  out  1  request in progress.
- mem_ren  out  1  memory read enable, registered.
- mem_raddr  out  AW  memory read address, registered.
- mem_rdata  in  P*Q  read data, valid the cycle after the memory samples ren/raddr.
- a  out  P*Q  operand a, registered, held.
- b  out  P*Q  operand b, registered, held.
- c  out  P*Q  operand c, registered, held.
- enable  out  1  one-cycle pulse: a/b/c valid for the array.

## Operation
- States: IDLE, RA, RB, RC, CAP, OUT.
- IDLE:
  - On start=1: latch addr_b, addr_c, c_zero.
  - mem_ren<=1, mem_raddr<=addr_a, go RA.
- RA: memory samples A. mem_raddr<=addr_b, mem_ren stays 1, go RB.
- RB:
  - Capture a<=mem_rdata.
  - If c_zero=0: mem_raddr<=addr_c, go RC.
  - If c_zero=1: mem_ren<=0, go CAP.
- RC: capture b<=mem_rdata, mem_ren<=0, go CAP.
- CAP:
  - c_zero=0: capture c<=mem_rdata.
  - c_zero=1: capture b<=mem_rdata, c<=0.
  - Set enable<=1, go OUT.
- OUT: enable<=0, go IDLE.
- busy = (state != IDLE), combinational from the state register.
- start while busy=1 is ignored and not queued. Address inputs change freely after acceptance.
- mem_raddr holds its last value when mem_ren=0.
- a/b/c hold until overwritten by the next request's captures. Only the enable cycle guarantees a coherent set.
- No arithmetic in this block. Data passes bit-exact, no saturation or sign change.
- Equal addresses, e.g. addr_a=addr_b, are legal; each read is issued independently.

## Timing
- Reset values: state=IDLE, busy=0, mem_ren=0, mem_raddr=0, a=b=c=0, enable=0.
- start accepted at edge E0.
  - c_zero=0: mem_ren high E0..E3. Addresses A, B, C are presented in the cycles after E0, E1, E2. enable is high for exactly the cycle after E4. busy is high from after E0 through the enable cycle.
  - c_zero=1: mem_ren high E0..E2. enable is high for the cycle after E3.
- Next start is accepted at the first edge where busy=0. Minimum request spacing: 6 cycles (c_zero=0), 5 cycles (c_zero=1).
- rst=1 at any edge, including mid-request: return to the reset values at that edge. An in-flight read is discarded. No enable pulse is produced for the aborted request.
- start and rst both high: rst wins.

## Test plan
- Reset: drive rst for 2 cycles with start=1 -> all outputs 0, busy=0, no mem_ren.
- Full fetch: memory[3]=lanes all 0x005, [7]=all 0x3FB, [9]=all 0x001. start, addr_a=3, addr_b=7, addr_c=9, c_zero=0 -> mem_raddr sequence 3,7,9 on consecutive cycles. enable pulses one cycle, 5 cycles after the start edge, with a=0x005…, b=0x3FB…, c=0x001…. The downstream f2 array yields d lanes = 0x3FC.
- c_zero: same memory, addr_a=3, addr_b=7, c_zero=1 -> only 2 reads, enable 4 cycles after the start edge, c=0.
- Busy rejection: pulse start again on each busy cycle with addr_a=9 -> no extra reads, first request completes unchanged.
- Reset mid-operation: assert rst in the RC cycle -> mem_ren=0 and busy=0 the next cycle, a=b=c=0, no enable.
- Back-to-back: assert start on the first cycle busy=0 after OUT -> accepted. Spacing between enable pulses is exactly 6 cycles.
